// File: rtl/spi_pkg.sv
// Shared types and default sizing for the SPI slave responder.
package spi_pkg;

  localparam int DATA_W_DEF      = 8;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for one asynchronous SPI pin, with rise/fall strobes
// taken from the last stage against one extra delay register.
module spi_sync_edge #(
  parameter int   STAGES   = 2,
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              last_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain  <= {STAGES{IDLE_VAL}};
      last_q <= IDLE_VAL;
    end else begin
      chain  <= {chain[STAGES-2:0], din};
      last_q <= chain[STAGES-1];
    end
  end

  assign sync = chain[STAGES-1];
  assign rise = sync & ~last_q;
  assign fall = ~sync & last_q;

endmodule

// File: rtl/spi_slave_responder.sv
// Mode-0 SPI slave: LSB-first shift in/out, one-word TX holding buffer and
// a valid/ready RX word port with overrun/underrun pulses.
module spi_slave_responder
  import spi_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              seq_clk,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              busy,
  output logic              overrun,
  output logic              underrun
);

  localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic cs_s, cs_rise, cs_fall;
  logic sck_s, sck_rise, sck_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset(reset), .din(cs), .sync(cs_s), .rise(cs_rise), .fall(cs_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_sck (
    .clk(clk), .reset(reset), .din(seq_clk), .sync(sck_s), .rise(sck_rise), .fall(sck_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .din(mosi), .sync(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  state_t            state, state_next;
  logic [SYNC_STAGES:0] flush;
  logic              armed;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] tx_shift, rx_shift, rx_next, hold_data;
  logic              hold_full;
  logic              in_shift, abort, start, at_last, load_pt, tx_wr;

  assign in_shift = (state == SHIFT);
  assign abort    = in_shift && cs_rise;
  assign start    = (state == IDLE) && cs_fall && armed;
  assign at_last  = (bit_cnt == LAST_BIT);
  assign load_pt  = start || (in_shift && !cs_rise && sck_fall && at_last);
  assign tx_wr    = tx_valid && tx_ready;

  assign tx_ready = !hold_full;
  assign busy     = in_shift;
  assign miso     = in_shift && tx_shift[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cs_fall && armed) state_next = SHIFT;
      SHIFT:   if (cs_rise)          state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // After reset the synchronizers hold idle levels that were never seen on the
  // pins; only arm once real samples show cs high and seq_clk low, so a frame
  // already in flight is ignored until its cs rises and falls again.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flush <= '0;
      armed <= 1'b0;
    end else begin
      flush <= {flush[SYNC_STAGES-1:0], 1'b1};
      if (flush[SYNC_STAGES] && cs_s && !sck_s) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_data <= '0;
      hold_full <= 1'b0;
    end else if (load_pt) begin
      // An empty-buffer load that coincides with a write keeps the new word.
      hold_full <= tx_wr;
      if (tx_wr) hold_data <= tx_data;
    end else if (tx_wr) begin
      hold_full <= 1'b1;
      hold_data <= tx_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_shift <= '0;
      bit_cnt  <= '0;
      underrun <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (load_pt) begin
        tx_shift <= hold_full ? hold_data : '0;
        underrun <= !hold_full;
      end else if (abort) begin
        tx_shift <= '0;
      end else if (in_shift && sck_fall) begin
        tx_shift <= tx_shift >> 1;
      end
      if (abort)                     bit_cnt <= '0;
      else if (in_shift && sck_fall) bit_cnt <= at_last ? '0 : bit_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    rx_next          = rx_shift;
    rx_next[bit_cnt] = mosi_s;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (abort) begin
        rx_shift <= '0;
      end else if (in_shift && sck_rise) begin
        rx_shift <= rx_next;
        if (at_last) begin
          rx_data  <= rx_next;
          rx_valid <= 1'b1;
          overrun  <= rx_valid && !rx_ready;
        end
      end
    end
  end

endmodule
